// File: rtl/cnn1d_result_sink.sv
// Purpose : terminates the cnn1d classifier stream; per frame reports argmax class and top-1/top-2 margin, keeps worn-tool counters and a sticky alarm.
// Latency : result valid the cycle after the last logit of a frame is accepted; minimum frame period NUM_NEURONS+1 cycles.
// Backpressure: input ready drops while a result is held; the result stays stable until sink_ready_out, and input bubbles just stall.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   sink_valid_in/data_in/ready_in    logit stream in, one signed logit per beat
//   sink_valid_out/ready_out          result handshake
//   sink_class_out, sink_margin_out   argmax index, best minus second-best (unsigned, DATA_WIDTH+1 bits)
//   alarm_clear, alarm                clear strobe and sticky worn alarm
//   frame_count, worn_count           saturating frame / worn-frame counters
module cnn1d_result_sink #(
    parameter int DATA_WIDTH      = 32,
    parameter int FRACTION        = 24,
    parameter int NUM_NEURONS     = 2,
    parameter int WORN_CLASS      = 1,
    parameter int ALARM_THRESHOLD = 3,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sink_valid_in,
    input  logic [DATA_WIDTH-1:0]          sink_data_in,
    output logic                           sink_ready_in,
    output logic                           sink_valid_out,
    input  logic                           sink_ready_out,
    output logic [$clog2(NUM_NEURONS)-1:0] sink_class_out,
    output logic [DATA_WIDTH:0]            sink_margin_out,
    input  logic                           alarm_clear,
    output logic                           alarm,
    output logic [COUNT_WIDTH-1:0]         frame_count,
    output logic [COUNT_WIDTH-1:0]         worn_count
);

    localparam int IDX_W  = $clog2(NUM_NEURONS);
    localparam int CONS_W = $clog2(ALARM_THRESHOLD + 1);

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_NEURONS - 1);
    localparam logic [IDX_W-1:0]      WORN_IDX = IDX_W'(WORN_CLASS);
    localparam logic [CONS_W-1:0]     CONS_MAX = CONS_W'(ALARM_THRESHOLD);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Parameter sanity, caught at elaboration.
    if (NUM_NEURONS < 2 || NUM_NEURONS > 64) begin : g_bad_neurons
        $error("cnn1d_result_sink: NUM_NEURONS must be 2..64");
    end
    if (ALARM_THRESHOLD < 1) begin : g_bad_threshold
        $error("cnn1d_result_sink: ALARM_THRESHOLD must be >= 1");
    end
    if (WORN_CLASS < 0 || WORN_CLASS >= NUM_NEURONS) begin : g_bad_worn
        $error("cnn1d_result_sink: WORN_CLASS out of range");
    end
    if (FRACTION < 0 || FRACTION > DATA_WIDTH) begin : g_bad_fraction
        $error("cnn1d_result_sink: FRACTION out of range");
    end

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_EMIT  = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0]  best_q, best_d;
    logic signed [DATA_WIDTH-1:0]  second_q, second_d;
    logic [IDX_W-1:0]              best_idx_q, best_idx_d;
    logic [COUNT_WIDTH-1:0]        frame_q, frame_d;
    logic [COUNT_WIDTH-1:0]        worn_q, worn_d;
    logic [CONS_W-1:0]             cons_q, cons_d;
    logic                          alarm_q, alarm_d;

    logic signed [DATA_WIDTH-1:0]  data_s;
    logic                          beat_acc;
    logic                          res_hs;
    logic                          is_worn;

    assign data_s   = sink_data_in;
    assign beat_acc = sink_valid_in && sink_ready_in;
    assign res_hs   = sink_valid_out && sink_ready_out;
    assign is_worn  = (best_idx_q == WORN_IDX);

    // Ready is gated by rst so nothing is taken while the block is being reset.
    assign sink_ready_in  = (state_q == ST_ACCUM) && !rst;
    assign sink_valid_out = (state_q == ST_EMIT);
    assign sink_class_out = best_idx_q;
    // best >= second always holds, so a one-bit sign extension of both
    // operands gives the exact non-negative difference in DATA_WIDTH+1 bits.
    assign sink_margin_out = {best_q[DATA_WIDTH-1], best_q} - {second_q[DATA_WIDTH-1], second_q};
    assign alarm       = alarm_q;
    assign frame_count = frame_q;
    assign worn_count  = worn_q;

    // Frame accumulation FSM: running top-2 tracking over the beats.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        best_d     = best_q;
        second_d   = second_q;
        best_idx_d = best_idx_q;
        case (state_q)
            ST_ACCUM: begin
                if (beat_acc) begin
                    if (idx_q == '0) begin
                        best_d     = data_s;
                        best_idx_d = '0;
                        second_d   = MOST_NEG;
                    end else if (data_s > best_q) begin
                        // Strict compare: on a tie the earlier index keeps the lead.
                        second_d   = best_q;
                        best_d     = data_s;
                        best_idx_d = idx_q;
                    end else if (data_s > second_q) begin
                        second_d = data_s;
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_EMIT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_EMIT: begin
                if (sink_ready_out) begin
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // Statistics, advanced only on the result handshake.
    always_comb begin
        frame_d = frame_q;
        worn_d  = worn_q;
        cons_d  = cons_q;
        alarm_d = alarm_q;
        if (res_hs) begin
            if (!(&frame_q)) begin
                frame_d = frame_q + COUNT_WIDTH'(1);
            end
            if (is_worn) begin
                if (!(&worn_q)) begin
                    worn_d = worn_q + COUNT_WIDTH'(1);
                end
                if (cons_q != CONS_MAX) begin
                    cons_d = cons_q + CONS_W'(1);
                end
            end else begin
                cons_d = '0;
            end
            if (cons_d == CONS_MAX) begin
                alarm_d = 1'b1;
            end
        end
        // Clear has priority over a same-cycle setting handshake.
        if (alarm_clear) begin
            alarm_d = 1'b0;
            cons_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ACCUM;
            idx_q      <= '0;
            best_q     <= '0;
            second_q   <= '0;
            best_idx_q <= '0;
            frame_q    <= '0;
            worn_q     <= '0;
            cons_q     <= '0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            second_q   <= second_d;
            best_idx_q <= best_idx_d;
            frame_q    <= frame_d;
            worn_q     <= worn_d;
            cons_q     <= cons_d;
            alarm_q    <= alarm_d;
        end
    end

endmodule

// File: doc/cnn1d_result_sink.md
Name: cnn1d_result_sink

Overview:
- Terminates the classifier output stream of cnn1d, the receiving end of its output valid/ready interface.
- Consumes one frame of NUM_NEURONS signed fixed-point logits, one beat per logit.
- Emits per frame: argmax class index and top-1/top-2 margin over its own valid/ready port.
- Keeps saturating frame and worn-tool counters, and a sticky alarm after ALARM_THRESHOLD consecutive worn frames.

Parameters:
- DATA_WIDTH, 32, logit width, two's complement, FRACTION fractional bits.
- FRACTION, 24, binary point position; informational only, arithmetic is scale-free.
- NUM_NEURONS, 2, logits per frame; legal range 2..64.
- WORN_CLASS, 1, class index counted as "worn".
- ALARM_THRESHOLD, 3, consecutive worn frames that raise alarm; legal range >= 1.
- COUNT_WIDTH, 16, width of frame_count and worn_count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- sink_valid_in  in  1  upstream logit valid
- sink_data_in  in  DATA_WIDTH  signed logit
- sink_ready_in  out  1  block accepts a logit this cycle
- sink_valid_out  out  1  result valid
- sink_ready_out  in  1  downstream accepts result
- sink_class_out  out  $clog2(NUM_NEURONS)  argmax index
- sink_margin_out  out  DATA_WIDTH+1  best minus second-best, unsigned
- alarm_clear  in  1  clears sticky alarm
- alarm  out  1  sticky worn alarm
- frame_count  out  COUNT_WIDTH  frames emitted, saturating
- worn_count  out  COUNT_WIDTH  frames with class==WORN_CLASS, saturating

Behaviour:
- Reset: state=ACCUM, beat index=0, sink_ready_in=0 during rst then 1, sink_valid_out=0, sink_class_out=0, sink_margin_out=0, alarm=0, frame_count=0, worn_count=0, consecutive counter=0.
- Reset mid-frame discards partial frame and any held result.
- State ACCUM:
  - sink_ready_in=1.
  - A beat is accepted when sink_valid_in && sink_ready_in.
  - Beat 0 loads best=data, best_idx=0, second=most-negative value.
  - Beat k>0:
    - if data > best (signed, strict): second=best, best=data, best_idx=k;
    - else if data > second: second=data.
  - Ties keep the lower index, since the comparison is strict.
  - Beat index increments per accepted beat. On accepting beat NUM_NEURONS-1, go to EMIT next cycle and wrap index to 0.
- State EMIT:
  - sink_ready_in=0; sink_valid_out=1.
  - class=best_idx; margin=best−second, computed at DATA_WIDTH+1 bits so it never overflows.
  - Outputs are stable while sink_ready_out=0.
  - On sink_valid_out && sink_ready_out, return to ACCUM next cycle.
- Latency and throughput:
  - sink_valid_out rises the cycle after the last logit is accepted.
  - Minimum frame period is NUM_NEURONS+1 cycles.
- Counters and alarm, updated on the result handshake cycle:
  - frame_count+1, saturating at all-ones.
  - If class==WORN_CLASS: worn_count+1 (saturating) and consecutive+1 (saturating at ALARM_THRESHOLD). Otherwise consecutive=0.
  - alarm sets when consecutive reaches ALARM_THRESHOLD and stays set.
  - alarm_clear clears alarm and consecutive. If alarm_clear coincides with a setting handshake, clear wins; consecutive restarts at 0 for that frame.
- Bubbles: sink_valid_in low mid-frame simply stalls accumulation, with no timeout.

Test Plan:
- Back-to-back, ready_out=1: logits 0x00800000, 0x01000000 -> class=1, margin=0x000800000, valid_out at cycle 3 after the first beat, frame_count=1, worn_count=1.
- Tie: 0x01000000, 0x01000000 -> class=0, margin=0; worn_count unchanged, consecutive reset.
- Negative extremes: 0x80000000, 0x7FFFFFFF -> class=1, margin=0x0FFFFFFFF with no overflow.
- Backpressure: hold ready_out=0 for 5 cycles in EMIT -> ready_in=0, outputs stable, upstream beats not consumed; result accepted on the 6th cycle.
- Alarm: ALARM_THRESHOLD=3, frames worn, worn, normal, worn, worn, worn -> alarm rises on the handshake of frame 6. Pulse alarm_clear -> alarm=0.
- Reset after one of two beats, then a full frame of 0x02000000, 0x00000000 -> class=0, margin=0x002000000, frame_count=1.
